// File: rtl/ips_dbc_trig_out_sched.sv
// rtl/ips_dbc_trig_out_sched.sv - round-robin trigger-output scheduler with serial config/readback
// Optional grant counter: define DBC_TRIG_SCHED_CNT_EN.
module ips_dbc_trig_out_sched #(
  parameter int         NUM_SRC   = 4,
  parameter int         PW_W      = 8,
  parameter logic [4:0] CONF_ID   = 5'd7,
  parameter logic [1:0] INIT_MODE = 2'b00
) (
  input  logic               clk_trig,
  input  logic               rst_trig,
  input  logic               conf_sel,
  input  logic               shift_i,
  input  logic               conf_tdi,
  input  logic [NUM_SRC-1:0] trig_req,
  output logic [NUM_SRC-1:0] trig_gnt,
  output logic               trig_out,
  output logic               busy,
  input  logic               conf_rden,
  input  logic [4:0]         conf_id,
  input  logic               conf_sel_rd,
  output logic               conf_rdlast,
  output logic               conf_rdata
);

  localparam int CFG_W = NUM_SRC + 2 + 2 * PW_W;
  localparam int RD_W  = CFG_W + 10;
  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int RC_W  = $clog2(RD_W + 1);

  localparam logic [CFG_W-1:0] CFG_RST = {{NUM_SRC{1'b1}}, INIT_MODE, {(2 * PW_W){1'b0}}};

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_ASSERT  = 2'b01;
  localparam logic [1:0] ST_HOLDOFF = 2'b10;
  localparam logic [1:0] ST_LATCHED = 2'b11;

  localparam logic [1:0] MODE_PULSE  = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_LATCH  = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  logic [CFG_W-1:0]   cfg_sh;
  logic [CFG_W-1:0]   cfg_act;
  logic               conf_sel_q;
  logic               apply;

  logic [PW_W-1:0]    holdoff;
  logic [PW_W-1:0]    pulse_width;
  logic [1:0]         mode;
  logic [NUM_SRC-1:0] en_mask;
  logic               mode_off;

  logic [NUM_SRC-1:0] req_m;
  logic [NUM_SRC-1:0] req_q;
  logic [NUM_SRC-1:0] req_rise;
  logic [NUM_SRC-1:0] pend;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   win_nxt;
  logic [NUM_SRC-1:0] win_vec;
  logic               win_found;
  logic               do_grant;
  int                 scan;

  logic [1:0]         state;
  logic [PW_W-1:0]    cnt;
  logic [7:0]         cnt_rd;

  logic [RD_W-1:0]    rd_sh;
  logic [RC_W-1:0]    rd_cnt;
  logic               rd_sel_q;
  logic               rd_act;
  logic               rd_snap;
  logic               rd_on;

  assign holdoff     = cfg_act[PW_W-1:0];
  assign pulse_width = cfg_act[2*PW_W-1:PW_W];
  assign mode        = cfg_act[2*PW_W+1:2*PW_W];
  assign en_mask     = cfg_act[CFG_W-1:2*PW_W+2];
  assign mode_off    = (mode == MODE_OFF);

  // The falling edge of conf_sel commits the shifted word and flushes all activity.
  assign apply = conf_sel_q & ~conf_sel;

  always_ff @(posedge clk_trig) begin
    if (rst_trig) begin
      cfg_sh     <= '0;
      cfg_act    <= CFG_RST;
      conf_sel_q <= 1'b0;
    end else begin
      conf_sel_q <= conf_sel;
      if (conf_sel & shift_i) begin
        cfg_sh <= {conf_tdi, cfg_sh[CFG_W-1:1]};
      end
      if (apply) begin
        cfg_act <= cfg_sh;
      end
    end
  end

  assign req_m    = trig_req & en_mask;
  assign req_rise = req_m & ~req_q;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      scan = int'(rr_ptr) + i;
      if (scan >= NUM_SRC) begin
        scan = scan - NUM_SRC;
      end
      if (!win_found && pend[PTR_W'(scan)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(scan);
      end
    end
  end

  always_comb begin
    win_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      win_vec[i] = win_found && (win_idx == PTR_W'(i));
    end
  end

  assign win_nxt  = (win_idx == PTR_W'(NUM_SRC - 1)) ? '0 : win_idx + PTR_W'(1);
  assign do_grant = (state == ST_IDLE) & win_found & ~mode_off & ~apply;

  // A fresh edge on the bit being granted survives the clear.
  always_ff @(posedge clk_trig) begin
    if (rst_trig) begin
      req_q <= '0;
      pend  <= '0;
    end else begin
      req_q <= req_m;
      if (apply || mode_off) begin
        pend <= '0;
      end else begin
        pend <= (pend & ~(do_grant ? win_vec : '0)) | req_rise;
      end
    end
  end

  always_ff @(posedge clk_trig) begin
    if (rst_trig) begin
      rr_ptr <= '0;
    end else if (do_grant) begin
      rr_ptr <= win_nxt;
    end
  end

  always_ff @(posedge clk_trig) begin
    if (rst_trig || apply) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      trig_out <= 1'b0;
      trig_gnt <= '0;
    end else begin
      trig_gnt <= '0;
      case (state)
        ST_IDLE: begin
          if (do_grant) begin
            state    <= ST_ASSERT;
            cnt      <= '0;
            trig_gnt <= win_vec;
            trig_out <= (mode == MODE_TOGGLE) ? ~trig_out : 1'b1;
          end
        end
        ST_ASSERT: begin
          if (cnt == pulse_width) begin
            cnt <= '0;
            if (mode == MODE_PULSE) begin
              trig_out <= 1'b0;
            end
            if (mode == MODE_LATCH) begin
              state <= ST_LATCHED;
            end else if (holdoff != '0) begin
              state <= ST_HOLDOFF;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + PW_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (cnt == holdoff - PW_W'(1)) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + PW_W'(1);
          end
        end
        ST_LATCHED: begin
          state <= ST_LATCHED;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef DBC_TRIG_SCHED_CNT_EN
  logic [7:0] grant_cnt;

  always_ff @(posedge clk_trig) begin
    if (rst_trig || apply) begin
      grant_cnt <= '0;
    end else if (do_grant && (grant_cnt != 8'hff)) begin
      grant_cnt <= grant_cnt + 8'd1;
    end
  end

  assign cnt_rd = grant_cnt;
`else
  assign cnt_rd = 8'h00;
`endif

  // Snapshot is taken once per selection; zeros shift in so over-reads return 0.
  assign rd_snap = conf_sel_rd & ~rd_sel_q & (conf_id == CONF_ID);
  assign rd_on   = rd_act & conf_sel_rd;

  always_ff @(posedge clk_trig) begin
    if (rst_trig) begin
      rd_sh    <= '0;
      rd_cnt   <= '0;
      rd_sel_q <= 1'b0;
      rd_act   <= 1'b0;
    end else begin
      rd_sel_q <= conf_sel_rd;
      if (rd_snap) begin
        rd_sh  <= {cnt_rd, state, cfg_act};
        rd_cnt <= '0;
        rd_act <= 1'b1;
      end else if (!conf_sel_rd) begin
        rd_act <= 1'b0;
      end else if (rd_act && conf_rden) begin
        rd_sh <= rd_sh >> 1;
        if (rd_cnt != RC_W'(RD_W)) begin
          rd_cnt <= rd_cnt + RC_W'(1);
        end
      end
    end
  end

  assign conf_rdata  = rd_on & rd_sh[0];
  assign conf_rdlast = rd_on & (rd_cnt == RC_W'(RD_W - 1));

endmodule

// File: tb/tb_ips_dbc_trig_out_sched.sv
// tb/tb_ips_dbc_trig_out_sched.sv - directed self-checking bench for ips_dbc_trig_out_sched
module tb_ips_dbc_trig_out_sched;

`ifdef DBC_TRIG_SCHED_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       conf_sel;
  logic       shift_i;
  logic       conf_tdi;
  logic [3:0] trig_req;
  logic [3:0] trig_gnt;
  logic       trig_out;
  logic       busy;
  logic       conf_rden;
  logic [4:0] conf_id;
  logic       conf_sel_rd;
  logic       conf_rdlast;
  logic       conf_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  logic [21:0] cfg_w;
  logic [31:0] rd_w;
  int          last_at;

  always #5 clk = ~clk;

  ips_dbc_trig_out_sched #(
    .NUM_SRC(4), .PW_W(8), .CONF_ID(5'd7), .INIT_MODE(2'b00)
  ) dut (
    .clk_trig(clk), .rst_trig(rst), .conf_sel(conf_sel), .shift_i(shift_i),
    .conf_tdi(conf_tdi), .trig_req(trig_req), .trig_gnt(trig_gnt),
    .trig_out(trig_out), .busy(busy), .conf_rden(conf_rden), .conf_id(conf_id),
    .conf_sel_rd(conf_sel_rd), .conf_rdlast(conf_rdlast), .conf_rdata(conf_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] mk(input logic [3:0] en, input logic [1:0] md,
                                     input logic [7:0] pw, input logic [7:0] ho);
    return {en, md, pw, ho};
  endfunction

  function automatic logic [31:0] exp_rd(input logic [7:0] n, input logic [1:0] st,
                                         input logic [21:0] c);
    return {(CNT_ON ? n : 8'd0), st, c};
  endfunction

  task automatic shift_cfg(input logic [21:0] w);
    for (int i = 0; i < 22; i++) begin
      conf_sel = 1'b1;
      shift_i  = 1'b1;
      conf_tdi = w[i];
      @(negedge clk);
    end
  endtask

  task automatic apply_cfg();
    conf_sel = 1'b0;
    shift_i  = 1'b0;
    conf_tdi = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_cfg(input logic [21:0] w);
    shift_cfg(w);
    apply_cfg();
  endtask

  task automatic read_back(output logic [31:0] w, output int last);
    w    = '0;
    last = -1;
    conf_id     = 5'd7;
    conf_sel_rd = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      w[i] = conf_rdata;
      if (conf_rdlast && last < 0) last = i;
      conf_rden = 1'b1;
      @(negedge clk);
    end
    chk("rd past end", {30'd0, conf_rdlast, conf_rdata}, 32'd0);
    conf_rden   = 1'b0;
    conf_sel_rd = 1'b0;
    @(negedge clk);
    chk("rd deselected", {30'd0, conf_rdlast, conf_rdata}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; conf_sel = 1'b0; shift_i = 1'b0; conf_tdi = 1'b0; trig_req = '0;
    conf_rden = 1'b0; conf_id = 5'd0; conf_sel_rd = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset trig_out", trig_out, 0);
    chk("reset trig_gnt", trig_gnt, 0);
    chk("reset busy", busy, 0);
    chk("reset rdata", conf_rdata, 0);
    chk("reset rdlast", conf_rdlast, 0);
    rst = 1'b0;
    repeat (7) @(negedge clk);

    // single request, default pulse config: grant and pulse two cycles later
    trig_req = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t1 gnt/out c%0d", c), {trig_gnt, trig_out}, (c == 2) ? 5'b00011 : 5'b00000);
      @(negedge clk);
    end

    // four simultaneous requests, pw=1 ho=2: grants 0..3 five cycles apart
    rst = 1'b1; trig_req = '0;
    @(negedge clk);
    rst = 1'b0;
    load_cfg(mk(4'hf, 2'b00, 8'd1, 8'd2));
    trig_req = 4'hf;
    for (int c = 0; c < 22; c++) begin
      logic [3:0] eg;
      logic       eo;
      eg = '0;
      eo = 1'b0;
      if (c >= 2 && c <= 17 && ((c - 2) % 5) == 0) eg = 4'b0001 << ((c - 2) / 5);
      if (c >= 2 && c <= 18 && ((c - 2) % 5) < 2) eo = 1'b1;
      chk($sformatf("t2 gnt/out c%0d", c), {trig_gnt, trig_out}, {eg, eo});
      @(negedge clk);
    end

    // latched mode holds until the next apply
    trig_req = '0;
    cfg_w = mk(4'hf, 2'b10, 8'd0, 8'd0);
    load_cfg(cfg_w);
    trig_req = 4'b0001;
    repeat (5) @(negedge clk);
    chk("t3 latched out/busy", {trig_out, busy}, 2'b11);
    read_back(rd_w, last_at);
    chk("t3 readback latched", rd_w, exp_rd(8'd1, 2'b11, cfg_w));
    shift_cfg(mk(4'hf, 2'b00, 8'd0, 8'd0));
    chk("t3 out before apply", trig_out, 1);
    apply_cfg();
    chk("t3 out/busy after apply", {trig_out, busy}, 2'b00);

    // en_mask 1010, rr_ptr=1 from the previous grant: sources 1 then 3
    trig_req = '0;
    cfg_w = mk(4'b1010, 2'b00, 8'd0, 8'd0);
    load_cfg(cfg_w);
    trig_req = 4'hf;
    for (int c = 0; c < 8; c++) begin
      logic [4:0] e;
      e = (c == 2) ? 5'b00101 : (c == 4) ? 5'b10001 : 5'b00000;
      chk($sformatf("t4 gnt/out c%0d", c), {trig_gnt, trig_out}, e);
      @(negedge clk);
    end
    read_back(rd_w, last_at);
    chk("t4 readback", rd_w, exp_rd(8'd2, 2'b00, cfg_w));
    chk("t4 rdlast position", last_at, 31);

    // apply during a long pulse aborts it and drops the pending source 1
    trig_req = '0;
    load_cfg(mk(4'hf, 2'b00, 8'd200, 8'd0));
    trig_req = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("t5 gnt/out c%0d", c), {trig_gnt, trig_out}, (c == 2) ? 5'b00011 : {4'b0000, c == 3});
      @(negedge clk);
    end
    shift_cfg(mk(4'hf, 2'b00, 8'd0, 8'd0));
    chk("t5 out before apply", {trig_out, busy}, 2'b11);
    apply_cfg();
    chk("t5 out/busy after apply", {trig_out, busy}, 2'b00);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("t5 flushed c%0d", c), {trig_gnt, trig_out, busy}, 6'b000000);
    end

    // toggle mode: output flips once per grant
    trig_req = '0;
    load_cfg(mk(4'hf, 2'b01, 8'd0, 8'd0));
    trig_req = 4'b0001;
    repeat (2) @(negedge clk);
    chk("t6 first toggle", {trig_gnt, trig_out}, 5'b00011);
    repeat (3) @(negedge clk);
    chk("t6 held high", {trig_gnt, trig_out, busy}, 6'b000010);
    trig_req = '0;
    @(negedge clk);
    trig_req = 4'b0001;
    repeat (2) @(negedge clk);
    chk("t6 second toggle", {trig_gnt, trig_out}, 5'b00010);

    // disabled mode: nothing is granted
    trig_req = '0;
    load_cfg(mk(4'hf, 2'b11, 8'd0, 8'd0));
    trig_req = 4'hf;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t7 disabled c%0d", c), {trig_gnt, trig_out, busy}, 6'b000000);
      @(negedge clk);
    end

    // three grants, then full readback
    trig_req = '0;
    cfg_w = mk(4'hf, 2'b00, 8'd3, 8'd1);
    load_cfg(cfg_w);
    trig_req = 4'b0111;
    repeat (25) @(negedge clk);
    chk("t8 idle", busy, 0);
    read_back(rd_w, last_at);
    chk("t8 readback", rd_w, exp_rd(8'd3, 2'b00, cfg_w));
    chk("t8 rdlast position", last_at, 31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ips_dbc_trig_out_sched.md
# ips_dbc_trig_out_sched

Trigger-output scheduler for the debug core. It arbitrates pending trigger events from up to NUM_SRC trigger units onto a single `trig_out` pin, using round-robin order. It shapes the output as a pulse, toggle or latched level with a holdoff gap, and exposes its configuration and status on the debug-core serial config and readback chain. It sits between the trigger units and the trigger-output pad logic, in the `clk_trig` domain.

## Interface
Parameters:
- NUM_SRC, 4: number of trigger requesters (1..8).
- PW_W, 8: width of the pulse-width and holdoff fields.
- CONF_ID, 5'd7: readback chain ID of this block.
- INIT_MODE, 2'b00: mode loaded at reset.

Ports:
- clk_trig  in  1  trigger-domain clock; the only clock.
- rst_trig  in  1  synchronous, active-high reset.
- conf_sel  in  1  config chain select (pre-synchronised to clk_trig).
- shift_i  in  1  config shift enable.
- conf_tdi  in  1  config serial data, LSB first.
- trig_req  in  NUM_SRC  per-source trigger request; rising edge = one event.
- trig_gnt  out  NUM_SRC  one-hot, one-cycle grant pulse.
- trig_out  out  1  shaped trigger output, registered.
- busy  out  1  FSM not in IDLE.
- conf_rden  in  1  readback shift strobe.
- conf_id  in  5  readback target ID.
- conf_sel_rd  in  1  readback select.
- conf_rdlast  out  1  last readback bit flag.
- conf_rdata  out  1  readback serial data.

## Operation
- Config word: CFG_W = NUM_SRC+2+2·PW_W bits, LSB first. Field order from the LSB is `holdoff[PW_W]`, `pulse_width[PW_W]`, `mode[2]`, `en_mask[NUM_SRC]`.
- Shifting: when `conf_sel & shift_i`, `cfg_sh <= {conf_tdi, cfg_sh[CFG_W-1:1]}`.
- Apply: on the cycle `conf_sel` falls, `cfg_act <= cfg_sh`. The same cycle forces a flush:
  - FSM goes to IDLE.
  - `trig_out` is cleared.
  - Pending bits, counters and the grant counter are cleared.
  - The round-robin pointer is kept.
- Reset values of `cfg_act`: `en_mask` = all ones, `mode` = INIT_MODE, `pulse_width` = 0, `holdoff` = 0.
- Event capture: `pend[i]` is set on a rising edge of `trig_req[i] & en_mask[i]`. It is cleared on grant. If a new edge arrives in the same cycle as the grant of the same bit, the set wins.
- Modes:
  - 00 pulse.
  - 01 toggle.
  - 10 latched.
  - 11 disabled: `pend` is held at 0 and no grants are issued.
- FSM states: IDLE, ASSERT, HOLDOFF, LATCHED.
  - IDLE: if any `pend` bit is set, grant the first set bit at or after `rr_ptr` (wrapping modulo NUM_SRC). Then `rr_ptr <= winner+1` (wrapping) and go to ASSERT.
  - ASSERT: lasts `pulse_width`+1 cycles. Afterwards go to HOLDOFF if `holdoff`≠0, otherwise IDLE. In mode 10, go to LATCHED instead.
  - HOLDOFF: lasts `holdoff` cycles, then IDLE.
  - LATCHED: terminal until a config apply or reset.
- Output shaping:
  - Pulse mode: `trig_out` = 1 exactly during ASSERT.
  - Toggle mode: `trig_out` inverts once at ASSERT entry.
  - Latched mode: `trig_out` = 1 from ASSERT entry until the flush.
- Grant counter: 8-bit, saturating at 255, counts grants.
- Readback word: RD_W = CFG_W+10, LSB first, `{grant_cnt[8], state[2], cfg_act}`.
  - Snapshot taken into `rd_sh` on the cycle `conf_sel_rd` rises while `conf_id==CONF_ID`.
  - While selected, each `conf_rden` cycle shifts `rd_sh` right by one and increments `rd_cnt`.
  - `conf_rdata = rd_sh[0]`; `conf_rdlast = (rd_cnt==RD_W-1)`.
  - When not selected, both outputs are 0.
  - Reading past bit RD_W-1 returns 0.

## Timing
- Reset (`rst_trig`=1 at a clock edge): `trig_out`=0, `trig_gnt`=0, `busy`=0, `conf_rdata`=0, `conf_rdlast`=0. Also `pend`=0, `rr_ptr`=0 and FSM = IDLE.
- Latency: `trig_req[i]` first high in cycle k (FSM idle, no contention) gives `trig_gnt[i]` and `trig_out` high in cycle k+2.
- Pulse mode: `trig_out` stays high for cycles k+2 .. k+2+`pulse_width`. The next grant is possible `holdoff` cycles later.
- `trig_gnt` is high only in the first ASSERT cycle.
- Config apply and reset mid-operation take effect on the next edge; no partial pulse continues.

## Configuration
- `DBC_TRIG_SCHED_CNT_EN` defined: the grant counter is implemented and read back.
- Not defined: counter logic is absent and readback bits [RD_W-1:RD_W-8] read 0. RD_W is unchanged, so host software is unaffected.

## Test plan
- Reset, then `trig_req`=4'b0001 rising at cycle 10 (pw=0, ho=0, mode 00) -> `trig_gnt`=4'b0001 and `trig_out`=1 in cycle 12 only.
- All four requests rise together, pw=1, ho=2 -> grants in order 0,1,2,3, spaced 5 cycles apart; `trig_out` high for 2 cycles each.
- Mode 10 with one request -> `trig_out` stays 1; a subsequent config apply drops `trig_out` to 0 on the next cycle and `busy`=0.
- `en_mask`=4'b1010 with requests on all sources -> only sources 1 and 3 are granted; the readback state field = IDLE afterwards.
- Config apply during ASSERT with pw=200 -> `trig_out`=0 on the next cycle and pending bits are lost.
- Readback after 3 grants -> 32 bits LSB first match `cfg_act`, state 00 and count 3 (0 without the macro); `conf_rdlast`=1 on bit 31.
